// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: state encodings
// and the default opcode assignments of the lab CPU instruction set.
package cpu_ctrl_pkg;

   // Controller states. The numeric values are visible on the debug
   // state port, so they are fixed explicitly rather than left to the tool.
   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEMORY    = 3'd3,
      WRITEBACK = 3'd4,
      HALT      = 3'd5
   } ctrl_state_e;

   // Default widths and opcodes used as parameter defaults by the controller.
   localparam int unsigned DEF_OP_W      = 4;
   localparam int unsigned DEF_CNT_W     = 16;
   localparam int unsigned DEF_OP_LOAD   = 9;
   localparam int unsigned DEF_OP_STORE  = 10;
   localparam int unsigned DEF_OP_BRANCH = 11;
   localparam int unsigned DEF_OP_HALT   = 15;

endpackage

// File: rtl/ctrl_retire_counter.sv
// Saturating counter of retired instructions. It sticks at its all-ones
// value instead of wrapping, so software never sees the count go backwards.
module ctrl_retire_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: step by one on a retire unless already saturated.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register; reset clears it immediately, independent of the clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the lab CPU datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback, handshakes
// with memory through mem_ready, honours a global stall and counts
// retired instructions.
module multicycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int              OP_W      = DEF_OP_W,
   parameter logic [OP_W-1:0] OP_LOAD   = OP_W'(DEF_OP_LOAD),
   parameter logic [OP_W-1:0] OP_STORE  = OP_W'(DEF_OP_STORE),
   parameter logic [OP_W-1:0] OP_BRANCH = OP_W'(DEF_OP_BRANCH),
   parameter logic [OP_W-1:0] OP_HALT   = OP_W'(DEF_OP_HALT),
   parameter int              CNT_W     = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OP_W-1:0]  op_type,
   input  logic             reg_imm,
   input  logic             branch_taken,
   input  logic             mem_ready,
   input  logic             stall,
   output logic             reg_write,
   output logic             IType,
   output logic             pc_en,
   output logic             pc_write,
   output logic             ir_en,
   output logic             mem_req,
   output logic             mem_we,
   output logic             halted,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   ctrl_state_e state_q;
   ctrl_state_e state_d;
   logic        retire;
   logic        isStore;

   assign isStore = (op_type == OP_STORE);

   // State register; an asynchronous reset drops back to FETCH at once,
   // abandoning whatever instruction was in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and strobes. The per-state decode comes first, then stall
   // overrides it by freezing the state and silencing every strobe, and
   // finally reset silences the strobes while it is held low.
   always_comb begin
      state_d   = state_q;
      reg_write = 1'b0;
      pc_en     = 1'b0;
      pc_write  = 1'b0;
      ir_en     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      halted    = 1'b0;
      retire    = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               pc_en   = 1'b1;
               ir_en   = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            state_d = (op_type == OP_HALT) ? HALT : EXECUTE;
         end
         EXECUTE: begin
            if (op_type == OP_BRANCH) begin
               pc_write = branch_taken;
               retire   = 1'b1;
               state_d  = FETCH;
            end else if ((op_type == OP_LOAD) || isStore) begin
               state_d = MEMORY;
            end else begin
               state_d = WRITEBACK;
            end
         end
         MEMORY: begin
            mem_req = 1'b1;
            mem_we  = isStore;
            if (mem_ready) begin
               if (isStore) begin
                  retire  = 1'b1;
                  state_d = FETCH;
               end else begin
                  state_d = WRITEBACK;
               end
            end
         end
         WRITEBACK: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
      if (stall) begin
         state_d   = state_q;
         reg_write = 1'b0;
         pc_en     = 1'b0;
         pc_write  = 1'b0;
         ir_en     = 1'b0;
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         retire    = 1'b0;
      end
      if (!rst_n) begin
         reg_write = 1'b0;
         pc_en     = 1'b0;
         pc_write  = 1'b0;
         ir_en     = 1'b0;
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         halted    = 1'b0;
         retire    = 1'b0;
      end
   end

   assign IType = reg_imm;
   assign state = state_q;

   ctrl_retire_counter #(
      .CNT_W (CNT_W)
   ) u_retire_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (retire),
      .count (instr_count)
   );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Each stimulus row pushes the
// expected outputs for that cycle into a queue; a monitor on the falling
// edge pops and compares. A second instance with a 2-bit counter shares
// the inputs so saturation can be observed.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic [2:0]  st;
      logic [6:0]  strb;
      logic        itype;
      logic [15:0] cnt;
      logic        chk2;
      logic [1:0]  cnt2;
   } expRow_t;

   logic        clk;
   logic        rstN;
   logic [3:0]  opType;
   logic        regImm;
   logic        branchTaken;
   logic        memReady;
   logic        stallIn;

   logic        regWrite, iType, pcEn, pcWrite, irEn, memReq, memWe, haltedOut;
   logic [2:0]  stateOut;
   logic [15:0] instrCount;

   logic        regWrite2, iType2, pcEn2, pcWrite2, irEn2, memReq2, memWe2, halted2;
   logic [2:0]  state2;
   logic [1:0]  instrCount2;

   expRow_t     expQ[$];
   int          checks;
   int          failures;

   multicycle_ctrl dut (
      .clk          (clk),
      .rst_n        (rstN),
      .op_type      (opType),
      .reg_imm      (regImm),
      .branch_taken (branchTaken),
      .mem_ready    (memReady),
      .stall        (stallIn),
      .reg_write    (regWrite),
      .IType        (iType),
      .pc_en        (pcEn),
      .pc_write     (pcWrite),
      .ir_en        (irEn),
      .mem_req      (memReq),
      .mem_we       (memWe),
      .halted       (haltedOut),
      .state        (stateOut),
      .instr_count  (instrCount)
   );

   multicycle_ctrl #(.CNT_W(2)) dutSat (
      .clk          (clk),
      .rst_n        (rstN),
      .op_type      (opType),
      .reg_imm      (regImm),
      .branch_taken (branchTaken),
      .mem_ready    (memReady),
      .stall        (stallIn),
      .reg_write    (regWrite2),
      .IType        (iType2),
      .pc_en        (pcEn2),
      .pc_write     (pcWrite2),
      .ir_en        (irEn2),
      .mem_req      (memReq2),
      .mem_we       (memWe2),
      .halted       (halted2),
      .state        (state2),
      .instr_count  (instrCount2)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one expected row against what the DUTs show right now.
   task automatic checkOutput(input expRow_t e);
      logic [6:0] actStrb;
      actStrb = {regWrite, pcEn, pcWrite, irEn, memReq, memWe, haltedOut};
      checks++;
      if (stateOut !== e.st) begin
         failures++;
         $display("[TB] FAIL state: got %0d want %0d at %0t", stateOut, e.st, $time);
      end
      checks++;
      if (actStrb !== e.strb) begin
         failures++;
         $display("[TB] FAIL strobes(rw,pe,pw,ie,mq,mw,h): got %b want %b at %0t", actStrb, e.strb, $time);
      end
      checks++;
      if (iType !== e.itype) begin
         failures++;
         $display("[TB] FAIL IType: got %b want %b at %0t", iType, e.itype, $time);
      end
      checks++;
      if (instrCount !== e.cnt) begin
         failures++;
         $display("[TB] FAIL instr_count: got %0d want %0d at %0t", instrCount, e.cnt, $time);
      end
      if (e.chk2) begin
         checks++;
         if (instrCount2 !== e.cnt2) begin
            failures++;
            $display("[TB] FAIL sat_count: got %0d want %0d at %0t", instrCount2, e.cnt2, $time);
         end
      end
   endtask

   // Monitor: whenever an expectation is queued, check it mid-cycle.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         checkOutput(expQ.pop_front());
      end
   end

   // Drive one cycle of inputs, queue its expected outputs, advance a cycle.
   task automatic applyStimulus(input logic [3:0] op, input logic bt, input logic mr,
                                input logic st, input logic [2:0] expState,
                                input logic [6:0] expStrb, input logic [15:0] expCnt,
                                input logic chk2, input logic [1:0] expCnt2);
      expRow_t e;
      opType      = op;
      regImm      = op[0];
      branchTaken = bt;
      memReady    = mr;
      stallIn     = st;
      e.st    = expState;
      e.strb  = expStrb;
      e.itype = op[0];
      e.cnt   = expCnt;
      e.chk2  = chk2;
      e.cnt2  = expCnt2;
      expQ.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // One ALU instruction (op 3) with memory always ready: F, D, E, W.
   task automatic runAluOp(input logic [15:0] c, input logic chk2, input logic [1:0] c2);
      applyStimulus(4'd3, 1'b0, 1'b1, 1'b0, 3'd0, 7'b0101100, c, chk2, c2);
      applyStimulus(4'd3, 1'b0, 1'b1, 1'b0, 3'd1, 7'b0000000, c, chk2, c2);
      applyStimulus(4'd3, 1'b0, 1'b1, 1'b0, 3'd2, 7'b0000000, c, chk2, c2);
      applyStimulus(4'd3, 1'b0, 1'b1, 1'b0, 3'd4, 7'b1000000, c, chk2, c2);
   endtask

   // Directed sequence; expected values worked out by hand per cycle.
   initial begin
      checks      = 0;
      failures    = 0;
      rstN        = 1'b0;
      opType      = 4'd0;
      regImm      = 1'b0;
      branchTaken = 1'b0;
      memReady    = 1'b1;
      stallIn     = 1'b0;
      @(posedge clk);
      #1;

      // Held in reset: everything quiet even with mem_ready high.
      applyStimulus(4'd3, 1'b0, 1'b1, 1'b0, 3'd0, 7'b0000000, 16'd0, 1'b1, 2'd0);
      applyStimulus(4'd3, 1'b0, 1'b1, 1'b0, 3'd0, 7'b0000000, 16'd0, 1'b1, 2'd0);
      rstN = 1'b1;

      // ALU op: states 0,1,2,4.
      runAluOp(16'd0, 1'b0, 2'd0);

      // Load with two not-ready cycles in MEMORY: 7 cycles total.
      applyStimulus(4'd9, 1'b0, 1'b1, 1'b0, 3'd0, 7'b0101100, 16'd1, 1'b0, 2'd0);
      applyStimulus(4'd9, 1'b0, 1'b1, 1'b0, 3'd1, 7'b0000000, 16'd1, 1'b0, 2'd0);
      applyStimulus(4'd9, 1'b0, 1'b1, 1'b0, 3'd2, 7'b0000000, 16'd1, 1'b0, 2'd0);
      applyStimulus(4'd9, 1'b0, 1'b0, 1'b0, 3'd3, 7'b0000100, 16'd1, 1'b0, 2'd0);
      applyStimulus(4'd9, 1'b0, 1'b0, 1'b0, 3'd3, 7'b0000100, 16'd1, 1'b0, 2'd0);
      applyStimulus(4'd9, 1'b0, 1'b1, 1'b0, 3'd3, 7'b0000100, 16'd1, 1'b0, 2'd0);
      applyStimulus(4'd9, 1'b0, 1'b1, 1'b0, 3'd4, 7'b1000000, 16'd1, 1'b0, 2'd0);

      // Store: write request in MEMORY, no register write.
      applyStimulus(4'd10, 1'b0, 1'b1, 1'b0, 3'd0, 7'b0101100, 16'd2, 1'b0, 2'd0);
      applyStimulus(4'd10, 1'b0, 1'b1, 1'b0, 3'd1, 7'b0000000, 16'd2, 1'b0, 2'd0);
      applyStimulus(4'd10, 1'b0, 1'b1, 1'b0, 3'd2, 7'b0000000, 16'd2, 1'b0, 2'd0);
      applyStimulus(4'd10, 1'b0, 1'b1, 1'b0, 3'd3, 7'b0000110, 16'd2, 1'b0, 2'd0);

      // Branch taken, then branch not taken.
      applyStimulus(4'd11, 1'b1, 1'b1, 1'b0, 3'd0, 7'b0101100, 16'd3, 1'b0, 2'd0);
      applyStimulus(4'd11, 1'b1, 1'b1, 1'b0, 3'd1, 7'b0000000, 16'd3, 1'b0, 2'd0);
      applyStimulus(4'd11, 1'b1, 1'b1, 1'b0, 3'd2, 7'b0010000, 16'd3, 1'b0, 2'd0);
      applyStimulus(4'd11, 1'b0, 1'b1, 1'b0, 3'd0, 7'b0101100, 16'd4, 1'b0, 2'd0);
      applyStimulus(4'd11, 1'b0, 1'b1, 1'b0, 3'd1, 7'b0000000, 16'd4, 1'b0, 2'd0);
      applyStimulus(4'd11, 1'b0, 1'b1, 1'b0, 3'd2, 7'b0000000, 16'd4, 1'b0, 2'd0);

      // Three stalled FETCH cycles with memory ready, then an ALU op.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'd3, 1'b0, 1'b1, 1'b1, 3'd0, 7'b0000000, 16'd5, 1'b0, 2'd0);
      end
      runAluOp(16'd5, 1'b0, 2'd0);

      // Store stalled once in MEMORY with mem_ready high: ready is ignored.
      applyStimulus(4'd10, 1'b0, 1'b1, 1'b0, 3'd0, 7'b0101100, 16'd6, 1'b0, 2'd0);
      applyStimulus(4'd10, 1'b0, 1'b1, 1'b0, 3'd1, 7'b0000000, 16'd6, 1'b0, 2'd0);
      applyStimulus(4'd10, 1'b0, 1'b1, 1'b0, 3'd2, 7'b0000000, 16'd6, 1'b0, 2'd0);
      applyStimulus(4'd10, 1'b0, 1'b1, 1'b1, 3'd3, 7'b0000000, 16'd6, 1'b0, 2'd0);
      applyStimulus(4'd10, 1'b0, 1'b1, 1'b0, 3'd3, 7'b0000110, 16'd6, 1'b0, 2'd0);

      // Halt: halted from the cycle after DECODE and it persists.
      applyStimulus(4'd15, 1'b0, 1'b1, 1'b0, 3'd0, 7'b0101100, 16'd7, 1'b0, 2'd0);
      applyStimulus(4'd15, 1'b0, 1'b1, 1'b0, 3'd1, 7'b0000000, 16'd7, 1'b0, 2'd0);
      for (int i = 0; i < 100; i++) begin
         applyStimulus(4'd15, 1'b0, 1'b1, 1'(i % 2), 3'd5, 7'b0000001, 16'd7, 1'b0, 2'd0);
      end

      // Reset dropped between edges: state and count clear before any edge.
      rstN = 1'b0;
      applyStimulus(4'd3, 1'b0, 1'b1, 1'b0, 3'd0, 7'b0000000, 16'd0, 1'b1, 2'd0);
      applyStimulus(4'd3, 1'b0, 1'b1, 1'b0, 3'd0, 7'b0000000, 16'd0, 1'b1, 2'd0);
      rstN = 1'b1;

      // Five ALU ops; the 2-bit counter saturates at 3.
      runAluOp(16'd0, 1'b1, 2'd0);
      runAluOp(16'd1, 1'b1, 2'd1);
      runAluOp(16'd2, 1'b1, 2'd2);
      runAluOp(16'd3, 1'b1, 2'd3);
      runAluOp(16'd4, 1'b1, 2'd3);
      applyStimulus(4'd3, 1'b0, 1'b0, 1'b0, 3'd0, 7'b0000100, 16'd5, 1'b1, 2'd3);

      // Every queued expectation must have been consumed by the monitor.
      @(negedge clk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL queue_drain: got %0d pending want 0", expQ.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
